// File: rtl/alu_2432_pkg.sv
// Shared constants for the 24-bit-instruction / 32-bit-data core: widths, opcodes,
// PSR bit indices and architectural register IDs.
package alu_2432_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned SHAM_W = 5;

  localparam logic [OP_W-1:0] OP_BRA_CC = 6'b000000;
  localparam logic [OP_W-1:0] OP_CALL_CC = 6'b000001;
  localparam logic [OP_W-1:0] OP_STO_B  = 6'b000010;
  localparam logic [OP_W-1:0] OP_STO_H  = 6'b000011;
  localparam logic [OP_W-1:0] OP_STO_W  = 6'b000100;
  localparam logic [OP_W-1:0] OP_LD_B   = 6'b001000;
  localparam logic [OP_W-1:0] OP_LD_H   = 6'b001001;
  localparam logic [OP_W-1:0] OP_LD_W   = 6'b001010;
  localparam logic [OP_W-1:0] OP_LJMP   = 6'b010000;
  localparam logic [OP_W-1:0] OP_LCALL  = 6'b010100;
  localparam logic [OP_W-1:0] OP_MOVT   = 6'b011000;
  localparam logic [OP_W-1:0] OP_ADD    = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB    = 6'b100001;
  localparam logic [OP_W-1:0] OP_AND    = 6'b100010;
  localparam logic [OP_W-1:0] OP_OR     = 6'b100011;
  localparam logic [OP_W-1:0] OP_XOR    = 6'b100100;
  localparam logic [OP_W-1:0] OP_LSL    = 6'b100101;
  localparam logic [OP_W-1:0] OP_ASR    = 6'b100110;
  localparam logic [OP_W-1:0] OP_MUL    = 6'b100111;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_V = 1;
  localparam int unsigned PSR_S = 2;
  localparam int unsigned PSR_Z = 3;

  localparam logic [3:0] REG_RZERO = 4'd0;
  localparam logic [3:0] REG_RPSR  = 4'd14;
  localparam logic [3:0] REG_RPC   = 4'd15;

endpackage

// File: rtl/alu_2432_shifter.sv
// 32-bit LSL/ASR barrel shifter; carry is the last bit shifted out, amount 0 passes A and cin.
module alu_2432_shifter
  import alu_2432_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [SHAM_W-1:0] amt,
  input  logic              asr,
  input  logic              cin,
  output logic [DATA_W-1:0] dout,
  output logic              cout
);

  logic        [DATA_W:0] lsl_ext;
  logic signed [DATA_W:0] asr_ext;

  // Extra bit above (LSL) or below (ASR) catches the last bit shifted out.
  assign lsl_ext = {1'b0, a} << amt;
  assign asr_ext = $signed({a, 1'b0}) >>> amt;

  always_comb begin
    dout = a;
    cout = cin;
    if (amt != '0) begin
      if (asr) begin
        dout = asr_ext[DATA_W:1];
        cout = asr_ext[0];
      end else begin
        dout = lsl_ext[DATA_W-1:0];
        cout = lsl_ext[DATA_W];
      end
    end
  end

endmodule

// File: rtl/alu_2432.sv
// Execute-stage ALU: add/sub/logic/shift/MOVT/pass-through, plus a two-cycle 32x32 multiply
// whose low-half partial product is held in pp_q.
module alu_2432
  import alu_2432_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic              cin,
  input  logic              vin,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] dout,
  output logic              cout,
  output logic              vout,
  output logic              mcp_out
);

  logic              is_mul;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_sum;
  logic [DATA_W-1:0] shf_dout;
  logic              shf_cout;
  logic [DATA_W-1:0] pp_next;
  logic [DATA_W-1:0] pp_hi;
  logic [DATA_W-1:0] pp_q;

  assign is_mul  = (opcode == OP_MUL);
  assign mcp_out = is_mul;

  assign add_sum = {1'b0, din_a} + {1'b0, din_b};
  assign sub_sum = {1'b0, din_a} + {1'b0, ~din_b} + 33'd1;

  assign pp_next = din_a * {16'h0000, din_b[15:0]};
  assign pp_hi   = din_a * {16'h0000, din_b[31:16]};

  alu_2432_shifter u_shifter (
    .a    (din_a),
    .amt  (din_b[SHAM_W-1:0]),
    .asr  (opcode == OP_ASR),
    .cin  (cin),
    .dout (shf_dout),
    .cout (shf_cout)
  );

  // Low partial product reloads on every MUL cycle so back-to-back MULs each get a capture cycle.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      pp_q <= '0;
    end else if (is_mul) begin
      pp_q <= pp_next;
    end
  end

  always_comb begin
    dout = din_b;
    cout = cin;
    vout = vin;
    case (opcode)
      OP_ADD: begin
        dout = add_sum[DATA_W-1:0];
        cout = add_sum[DATA_W];
        vout = (din_a[31] == din_b[31]) && (add_sum[31] != din_a[31]);
      end
      OP_SUB: begin
        dout = sub_sum[DATA_W-1:0];
        cout = sub_sum[DATA_W];
        vout = (din_a[31] != din_b[31]) && (sub_sum[31] != din_a[31]);
      end
      OP_AND:  dout = din_a & din_b;
      OP_OR:   dout = din_a | din_b;
      OP_XOR:  dout = din_a ^ din_b;
      OP_LSL, OP_ASR: begin
        dout = shf_dout;
        cout = shf_cout;
      end
      OP_MOVT: dout = {din_b[15:0], din_a[15:0]};
      OP_MUL:  dout = pp_q + (pp_hi << 16);
      // Loads, stores, branches, jumps and reserved opcodes pass B through.
      default: dout = din_b;
    endcase
  end

endmodule

// File: tb/tb_alu_2432.sv
// Scoreboard bench for alu_2432: directed vectors push expectations, a negedge monitor checks them.
module tb_alu_2432;

  logic        i_clk;
  logic        i_rstb;
  logic [31:0] din_a;
  logic [31:0] din_b;
  logic        cin;
  logic        vin;
  logic [5:0]  opcode;
  logic [31:0] dout;
  logic        cout;
  logic        vout;
  logic        mcp_out;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        cout;
    logic        vout;
    logic        mcp;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100001, AND_ = 6'b100010, OR_ = 6'b100011;
  localparam logic [5:0] XOR_ = 6'b100100, LSL = 6'b100101, ASR = 6'b100110, MUL = 6'b100111;
  localparam logic [5:0] MOVT = 6'b011000, LD_W = 6'b001010, RSVD = 6'b111111;

  alu_2432 dut (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .din_a   (din_a),
    .din_b   (din_b),
    .cin     (cin),
    .vin     (vin),
    .opcode  (opcode),
    .dout    (dout),
    .cout    (cout),
    .vout    (vout),
    .mcp_out (mcp_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge i_clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ((mcp_out !== e.mcp) ||
          (e.chk_data && ((dout !== e.dout) || (cout !== e.cout) || (vout !== e.vout)))) begin
        errors++;
        $display("FAIL %s: got dout=%h cout=%b vout=%b mcp=%b, want dout=%h cout=%b vout=%b mcp=%b (data checked=%b)",
                 e.name, dout, cout, vout, mcp_out, e.dout, e.cout, e.vout, e.mcp, e.chk_data);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] ed, input logic ec, input logic ev,
                      input logic em, input logic chk);
    exp_t e;
    e.name = nm; e.dout = ed; e.cout = ec; e.vout = ev; e.mcp = em; e.chk_data = chk;
    exp_q.push_back(e);
  endtask

  task automatic apply(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic v,
                       input logic [31:0] ed, input logic ec, input logic ev,
                       input logic em, input logic chk);
    @(posedge i_clk);
    #1;
    opcode = op; din_a = a; din_b = b; cin = c; vin = v;
    push(nm, ed, ec, ev, em, chk);
  endtask

  initial begin
    int wait_cycles;
    i_rstb = 1'b0;
    opcode = ADD; din_a = '0; din_b = '0; cin = 1'b0; vin = 1'b0;

    // In reset pp_q is 0, so MUL shows only the high partial product: (0x1234*2)<<16.
    apply("reset_mul_ppq", MUL, 32'h0000_1234, 32'h0002_0001, 0, 0, 32'h2468_0000, 0, 0, 1, 1);
    @(posedge i_clk); #1; i_rstb = 1'b1;
    push("reset_release_mul_ppq", 32'h2468_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    apply("add_wrap",     ADD,  32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0000_0000, 1, 0, 0, 1);
    apply("add_ovf",      ADD,  32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
    apply("sub_borrow",   SUB,  32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 1);
    apply("sub_ovf",      SUB,  32'h8000_0000, 32'h1, 0, 0, 32'h7FFF_FFFF, 1, 1, 0, 1);
    apply("sub_zero_m1",  SUB,  32'h0, 32'h1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    apply("and",          AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 0, 32'h00F0_00F0, 1, 0, 0, 1);
    apply("or",           OR_,  32'hF000_0000, 32'h0000_000F, 0, 1, 32'hF000_000F, 0, 1, 0, 1);
    apply("xor",          XOR_, 32'hAAAA_5555, 32'hFFFF_0000, 1, 1, 32'h5555_5555, 1, 1, 0, 1);
    apply("lsl_1",        LSL,  32'h8000_0001, 32'h1, 0, 0, 32'h0000_0002, 1, 0, 0, 1);
    apply("lsl_31_hib",   LSL,  32'h0000_0001, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000, 0, 1, 0, 1);
    apply("asr_4",        ASR,  32'h8000_0000, 32'h4, 1, 0, 32'hF800_0000, 0, 0, 0, 1);
    apply("asr_2_carry",  ASR,  32'h0000_000F, 32'h2, 0, 0, 32'h0000_0003, 1, 0, 0, 1);
    apply("asr_0",        ASR,  32'h1234_5678, 32'h0, 1, 0, 32'h1234_5678, 1, 0, 0, 1);
    apply("lsl_0",        LSL,  32'h8765_4321, 32'hFFFF_FFE0, 0, 1, 32'h8765_4321, 0, 1, 0, 1);
    apply("movt",         MOVT, 32'h1234_5678, 32'h0000_ABCD, 0, 0, 32'hABCD_5678, 0, 0, 0, 1);
    apply("ld_w",         LD_W, 32'hFFFF_FFFF, 32'h0000_0100, 1, 1, 32'h0000_0100, 1, 1, 0, 1);
    apply("reserved",     RSVD, 32'h1111_1111, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 0, 1, 0, 1);

    // 0x12345 * 0x10003 = 0x1_2348_69CF.
    apply("mul1_c1",      MUL,  32'h0001_2345, 32'h0001_0003, 1, 0, 32'h0, 0, 0, 1, 0);
    apply("mul1_c2",      MUL,  32'h0001_2345, 32'h0001_0003, 1, 0, 32'h2348_69CF, 1, 0, 1, 1);
    // Back-to-back: 0x1234 * 0x20001 = 0x2468_1234.
    apply("mul2_c1",      MUL,  32'h0000_1234, 32'h0002_0001, 0, 1, 32'h0, 0, 1, 1, 0);
    apply("mul2_c2",      MUL,  32'h0000_1234, 32'h0002_0001, 0, 1, 32'h2468_1234, 0, 1, 1, 1);
    apply("after_mul",    ADD,  32'h0000_0010, 32'h0000_0020, 0, 0, 32'h0000_0030, 0, 0, 0, 1);

    // Reset mid-MUL: pp_q loads on the first cycle, then reset clears it.
    apply("mulr_c1",      MUL,  32'h0000_1234, 32'h0002_0001, 0, 0, 32'h0, 0, 0, 1, 0);
    @(posedge i_clk); #1; i_rstb = 1'b0;
    push("mulr_cleared", 32'h2468_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge i_clk); #2; i_rstb = 1'b1;
    // 0xFFFFFFFF^2 low 32 bits = 1.
    apply("mul3_c1",      MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 0, 1, 0);
    apply("mul3_c2",      MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0000_0001, 0, 0, 1, 1);
    apply("tail",         XOR_, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge i_clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
